alu: RTL and testbench

- 16-bit arithmetic/logic unit of the LITE-16 datapath.
- Each cycle it computes one of eight operations selected by codeop, in register-register or register-immediate form.
- It also forwards load data or computes a PC-relative jump target.
- Result and compare flag are registered and feed register-file writeback and branch logic.

---
 rtl/alu.sv | 86 ++++++++
 tb/tb_alu.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu.sv
// LITE-16 ALU: one-cycle registered result and sticky compare flag.
// Define ALU_ARITH_SHIFT_EN to make codeop 110 an arithmetic right shift.
module alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       codeop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] data_mem_out,
  input  logic             ri,
  input  logic             ld,
  input  logic             jmp,
  output logic [WIDTH-1:0] r,
  output logic             cmp
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpCmp = 3'b111;

  logic [WIDTH-1:0] r_q, r_d;
  logic             cmp_q, cmp_d;
  logic [WIDTH-1:0] op1, op2, alu_res;
  logic [3:0]       shamt;

  always_comb begin
    op1   = ri ? rd : a;
    op2   = b;
    shamt = op2[3:0];
    alu_res = '0;
    unique case (codeop)
      OpAdd: alu_res = op1 + op2;
      OpSub: alu_res = op1 - op2;
      OpAnd: alu_res = op1 & op2;
      OpOr:  alu_res = op1 | op2;
      OpXor: alu_res = op1 ^ op2;
      OpShl: alu_res = op1 << shamt;
`ifdef ALU_ARITH_SHIFT_EN
      OpShr: alu_res = $signed(op1) >>> shamt;
`else
      OpShr: alu_res = op1 >> shamt;
`endif
      OpCmp: alu_res = op1 - op2;
      default: alu_res = '0;
    endcase
  end

  // Load beats jump beats the ALU; cmp only moves on an unmasked CMP.
  always_comb begin
    r_d   = r_q;
    cmp_d = cmp_q;
    if (ld) begin
      r_d = data_mem_out;
    end else if (jmp) begin
      r_d = pc + b;
    end else begin
      r_d = alu_res;
      if (codeop == OpCmp) begin
        cmp_d = (op1 == op2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      cmp_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      cmp_q <= cmp_d;
    end
  end

  assign r   = r_q;
  assign cmp = cmp_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors with hand-computed results.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  codeop;
  logic [15:0] a, b, rd, pc, data_mem_out;
  logic        ri, ld, jmp;
  logic [15:0] r;
  logic        cmp;

  typedef struct {
    logic [15:0] exp_r;
    logic        exp_cmp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .codeop       (codeop),
    .a            (a),
    .b            (b),
    .rd           (rd),
    .pc           (pc),
    .data_mem_out (data_mem_out),
    .ri           (ri),
    .ld           (ld),
    .jmp          (jmp),
    .r            (r),
    .cmp          (cmp)
  );

  task automatic issue(input logic rst_v, input logic [2:0] op, input logic [15:0] a_v,
                       input logic [15:0] b_v, input logic [15:0] rd_v, input logic [15:0] pc_v,
                       input logic [15:0] dm_v, input logic ri_v, input logic ld_v,
                       input logic jmp_v, input logic [15:0] er, input logic ec,
                       input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = rst_v; codeop = op; a = a_v; b = b_v; rd = rd_v; pc = pc_v;
    data_mem_out = dm_v; ri = ri_v; ld = ld_v; jmp = jmp_v;
    e.exp_r = er; e.exp_cmp = ec; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: each edge consumes the vector issued on the preceding negedge.
  initial begin
    int   n;
    exp_t e;
    forever begin
      @(posedge clk);
      n = sb.size();
      #1;
      if (n > 0) begin
        e = sb.pop_front();
        checks++;
        if (r !== e.exp_r || cmp !== e.exp_cmp) begin
          failures++;
          $display("FAIL %s: got r=%h cmp=%b expected r=%h cmp=%b",
                   e.name, r, cmp, e.exp_r, e.exp_cmp);
        end
      end
    end
  end

  logic [15:0] reg_exp [8];
  logic [15:0] imm_exp [8];
  logic [15:0] shr1_exp;

  initial begin
    reg_exp = '{16'h000D, 16'h0001, 16'h0006, 16'h0007,
                16'h0001, 16'h01C0, 16'h0000, 16'h0001};
    imm_exp = '{16'h000B, 16'hFFFF, 16'h0004, 16'h0007,
                16'h0003, 16'h0140, 16'h0000, 16'hFFFF};
`ifdef ALU_ARITH_SHIFT_EN
    shr1_exp = 16'hC000;
`else
    shr1_exp = 16'h4000;
`endif
    rst_n = 1'b0; codeop = '0; a = '0; b = '0; rd = '0; pc = '0;
    data_mem_out = '0; ri = 1'b0; ld = 1'b0; jmp = 1'b0;

    // Reset with busy inputs
    issue(0, 3'd0, 16'h1234, 16'h1111, 16'h0, 16'h0, 16'hBEEF, 0, 1, 0, 16'h0000, 0, "reset0");
    issue(0, 3'd7, 16'h0005, 16'h0005, 16'h0, 16'h0, 16'h0,    0, 0, 1, 16'h0000, 0, "reset1");

    for (int i = 0; i < 8; i++)
      issue(1, 3'(i), 16'h0007, 16'h0006, 16'h0, 16'h0, 16'h0, 0, 0, 0, reg_exp[i], 0,
            $sformatf("reg_op%0d", i));
    for (int i = 0; i < 8; i++)
      issue(1, 3'(i), 16'hAAAA, 16'h0006, 16'h0005, 16'h0, 16'h0, 1, 0, 0, imm_exp[i], 0,
            $sformatf("imm_op%0d", i));

    issue(1, 3'd7, 16'hAAAA, 16'h0006, 16'h0006, 16'h0, 16'h0, 1, 0, 0, 16'h0000, 1, "cmp_eq");
    issue(1, 3'd0, 16'hAAAA, 16'h0006, 16'h0006, 16'h0, 16'h0, 1, 0, 0, 16'h000C, 1, "cmp_sticky");

    issue(1, 3'd1, 16'h0, 16'h0006, 16'h0, 16'h0100, 16'hBEEF, 0, 1, 0, 16'hBEEF, 1, "load");
    issue(1, 3'd1, 16'h0, 16'h0006, 16'h0, 16'h0100, 16'hBEEF, 0, 0, 1, 16'h0106, 1, "jump");
    issue(1, 3'd1, 16'h0, 16'h0006, 16'h0, 16'h0100, 16'hBEEF, 0, 1, 1, 16'hBEEF, 1, "ld_over_jmp");
    issue(1, 3'd0, 16'h0, 16'h0004, 16'h0, 16'hFFFE, 16'h0,    0, 0, 1, 16'h0002, 1, "jump_wrap");
    // CMP masked by ld/jmp must leave cmp alone
    issue(1, 3'd7, 16'h0001, 16'h0002, 16'h0, 16'h0010, 16'h5A5A, 0, 1, 0, 16'h5A5A, 1, "ld_cmp_hold");
    issue(1, 3'd7, 16'h0001, 16'h0002, 16'h0, 16'h0010, 16'h0,    0, 0, 1, 16'h0012, 1, "jmp_cmp_hold");

    issue(1, 3'd6, 16'h8001, 16'h0001, 16'h0, 16'h0, 16'h0, 0, 0, 0, shr1_exp,  1, "shr1");
    issue(1, 3'd6, 16'h8001, 16'h0011, 16'h0, 16'h0, 16'h0, 0, 0, 0, shr1_exp,  1, "shr_hi_ignored");
    issue(1, 3'd6, 16'h8001, 16'h0000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'h8001, 1, "shr0");
    issue(1, 3'd5, 16'h8001, 16'h001F, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'h8000, 1, "shl15");

    issue(1, 3'd0, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'h0000, 1, "add_wrap");
    issue(1, 3'd1, 16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'hFFFF, 1, "sub_wrap");
    issue(1, 3'd7, 16'h0001, 16'h0002, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'hFFFF, 0, "cmp_ne");
    issue(1, 3'd7, 16'h0003, 16'h0003, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'h0000, 1, "cmp_eq2");

    // Mid-stream reset
    issue(0, 3'd0, 16'h1234, 16'h4321, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'h0000, 0, "reset_mid");
    issue(1, 3'd4, 16'h00F0, 16'h0FF0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'h0F00, 0, "after_reset");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
